// File: rtl/mem_to_core_serial_tx.sv
// Memory-side MTOC serializer: a small input FIFO feeding a framed, oversampled
// single-wire transmitter (start, data LSB-first, optional even parity, stop).
module mem_to_core_serial_tx #(
   parameter int DATA_WIDTH = 28,
   parameter int CLK_DIV    = 32,
   parameter int FIFO_DEPTH = 2,
   parameter int PARITY_EN  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  serial_out,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_WIDTH + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count, count_n;
   logic                  push, pop, empty;

   state_t                state, state_n;
   logic [DIV_W-1:0]      div_cnt, div_n;
   logic [BIT_W-1:0]      bit_cnt, bit_n;
   logic [DATA_WIDTH-1:0] shift, shift_n;
   logic                  par, par_n;
   logic                  bit_end;
   logic                  serial_n, busy_n, frame_done_n;

   assign push    = in_valid & in_ready;
   assign empty   = (count == '0);
   assign bit_end = (div_cnt == DIV_LAST);

   always_comb begin
      count_n = count;
      if (push && !pop) begin
         count_n = count + CNT_W'(1);
      end else if (!push && pop) begin
         count_n = count - CNT_W'(1);
      end
   end

   // Storage carries no reset; only the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // in_ready is registered from the next count so it reflects fullness of the current cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         in_ready <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
         end
         count    <= count_n;
         in_ready <= (count_n != CNT_FULL);
      end
   end

   always_comb begin
      state_n = state;
      div_n   = bit_end ? '0 : div_cnt + DIV_W'(1);
      bit_n   = bit_cnt;
      shift_n = shift;
      par_n   = par;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            div_n = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_n = mem[rd_ptr];
               par_n   = ^mem[rd_ptr];
               state_n = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               bit_n   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_n = shift >> 1;
               if (bit_cnt == BIT_LAST) begin
                  state_n = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_n = bit_cnt + BIT_W'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_n = STOP;
            end
         end
         STOP: begin
            // Back-to-back frames: the next word is popped in the final stop cycle.
            if (bit_end) begin
               if (!empty) begin
                  pop     = 1'b1;
                  shift_n = mem[rd_ptr];
                  par_n   = ^mem[rd_ptr];
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      case (state_n)
         START:   serial_n = 1'b0;
         DATA:    serial_n = shift_n[0];
         PARITY:  serial_n = par_n;
         default: serial_n = 1'b1;
      endcase
      busy_n       = (state_n != IDLE);
      frame_done_n = (state_n == STOP) && (div_n == DIV_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         par        <= 1'b0;
         serial_out <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         div_cnt    <= div_n;
         bit_cnt    <= bit_n;
         shift      <= shift_n;
         par        <= par_n;
         serial_out <= serial_n;
         busy       <= busy_n;
         frame_done <= frame_done_n;
      end
   end

endmodule

// File: tb/tb_mem_to_core_serial_tx.sv
// Bench for mem_to_core_serial_tx: a mid-bit receiver model decodes the line and
// checks it against a scoreboard of accepted words; hand sequences cover timing corners.
module tb_mem_to_core_serial_tx;

   logic        clk;
   logic        rst;
   logic        in_valid, in_ready, serial_out, busy, frame_done;
   logic [27:0] in_data;
   logic        valid_b, ready_b, serial_b, busy_b, done_b;
   logic [27:0] data_b;

   typedef struct {
      logic [27:0] data;
      logic        par;
   } exp_t;

   exp_t exp_q[$];
   exp_t vecs[8];

   int vec_count   = 0;
   int miscompares = 0;
   int cyc         = 0;
   int fd_count    = 0;
   int fd_cyc[$];
   bit mon_on      = 1'b1;
   bit rx_busy     = 1'b0;
   bit rx_ok;
   logic [29:0] rx_bits;
   logic        rx_start;

   mem_to_core_serial_tx dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .serial_out(serial_out), .busy(busy), .frame_done(frame_done)
   );

   mem_to_core_serial_tx #(.CLK_DIV(4), .PARITY_EN(0)) dut_b (
      .clk(clk), .rst(rst), .in_valid(valid_b), .in_data(data_b),
      .in_ready(ready_b), .serial_out(serial_b), .busy(busy_b), .frame_done(done_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_done) begin
         fd_count++;
         fd_cyc.push_back(cyc);
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic expLevel(input int k, input logic [27:0] d, input logic p,
                                     input int div, input int has_par);
      int b;
      if (k < 2) return 1'b1;
      b = (k - 2) / div;
      if (b == 0) return 1'b0;
      if (b <= 28) return d[b-1];
      if (has_par != 0 && b == 29) return p;
      return 1'b1;
   endfunction

   // Offers one word, waits (bounded) for acceptance and records it in the scoreboard.
   task automatic applyStimulus(input logic [27:0] data, input logic par);
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = data;
      for (int n = 0; n < 3000 && !in_ready; n++) @(negedge clk);
      if (in_ready) begin
         e.data = data;
         e.par  = par;
         exp_q.push_back(e);
      end else begin
         checkOutput("push timeout", 32'd0, 32'd1);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while (n < budget && (exp_q.size() != 0 || rx_busy || busy)) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) checkOutput("drain timeout", 32'd1, 32'd0);
   endtask

   // Receiver model: detects the start edge, samples each bit at its centre.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_on && !rst && serial_out === 1'b0) begin
            rx_busy = 1'b1;
            rx_ok   = 1'b1;
            for (int i = 0; i < 16 && rx_ok; i++) begin
               @(negedge clk);
               if (!mon_on) rx_ok = 1'b0;
            end
            rx_start = serial_out;
            for (int b = 0; b < 30 && rx_ok; b++) begin
               for (int i = 0; i < 32 && rx_ok; i++) begin
                  @(negedge clk);
                  if (!mon_on) rx_ok = 1'b0;
               end
               rx_bits[b] = serial_out;
            end
            if (rx_ok) begin
               if (exp_q.size() == 0) begin
                  checkOutput("rx unexpected frame", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("rx start", {31'd0, rx_start}, 32'd0);
                  checkOutput("rx data", {4'd0, rx_bits[27:0]}, {4'd0, e.data});
                  checkOutput("rx parity", {31'd0, rx_bits[28]}, {31'd0, e.par});
                  checkOutput("rx stop", {31'd0, rx_bits[29]}, 32'd1);
               end
            end
            rx_busy = 1'b0;
         end
      end
   end

   initial begin : main
      int   t0, errs, fd_seen, zeros, fd_before;
      exp_t e;
      logic [27:0] words[4];

      vecs[0] = '{28'h0000003, 1'b0};
      vecs[1] = '{28'hFFFFFFF, 1'b0};
      vecs[2] = '{28'h0000007, 1'b1};
      vecs[3] = '{28'h0000001, 1'b1};
      vecs[4] = '{28'hA5A5A5A, 1'b0};
      vecs[5] = '{28'h8000000, 1'b1};
      vecs[6] = '{28'h0F0F0F0, 1'b0};
      vecs[7] = '{28'h1234567, 1'b0};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; valid_b = 1'b0; data_b = '0;
      repeat (3) @(negedge clk);
      checkOutput("por serial_out", {31'd0, serial_out}, 32'd1);
      checkOutput("por busy", {31'd0, busy}, 32'd0);
      checkOutput("por frame_done", {31'd0, frame_done}, 32'd0);
      checkOutput("por in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("por ready after", {31'd0, in_ready}, 32'd1);

      // Three-cycle reset while idle.
      repeat (5) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("rst in_ready", {31'd0, in_ready}, 32'd0);
         checkOutput("rst serial_out", {31'd0, serial_out}, 32'd1);
         checkOutput("rst busy", {31'd0, busy}, 32'd0);
         checkOutput("rst frame_done", {31'd0, frame_done}, 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst ready after", {31'd0, in_ready}, 32'd1);

      // Single word: cycle-exact waveform against the frame model.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 28'h0000001;
      checkOutput("single in_ready", {31'd0, in_ready}, 32'd1);
      e.data = 28'h0000001; e.par = 1'b1;
      exp_q.push_back(e);
      errs = 0; fd_seen = 0;
      for (int k = 1; k <= 995; k++) begin
         @(negedge clk);
         if (k == 1) in_valid = 1'b0;
         if (serial_out !== expLevel(k, 28'h0000001, 1'b1, 32, 1)) errs++;
         if (busy !== (k >= 2 && k <= 993)) errs++;
         if (frame_done !== (k == 993)) errs++;
         if (frame_done === 1'b1) fd_seen++;
      end
      checkOutput("single waveform errs", errs, 32'd0);
      checkOutput("single frame_done count", fd_seen, 32'd1);
      waitDrain(200);

      // Table of words: receiver decode and parity against the table.
      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].data, vecs[v].par);
         waitDrain(1200);
         checkOutput("table idle busy", {31'd0, busy}, 32'd0);
         checkOutput("table idle line", {31'd0, serial_out}, 32'd1);
      end

      // Back-pressure: four words offered back to back from idle.
      words[0] = 28'h0ABCDEF; words[1] = 28'h1111111;
      words[2] = 28'h2468ACE; words[3] = 28'h7654321;
      fd_cyc.delete();
      @(negedge clk);
      t0 = cyc;
      in_valid = 1'b1;
      for (int w = 0; w < 3; w++) begin
         in_data = words[w];
         checkOutput("bp ready", {31'd0, in_ready}, 32'd1);
         e.data = words[w]; e.par = ^words[w];
         exp_q.push_back(e);
         @(negedge clk);
      end
      in_data = words[3];
      zeros = 0;
      while (!in_ready && zeros < 3000) begin
         zeros++;
         @(negedge clk);
      end
      checkOutput("bp stall cycles", zeros, 32'd991);
      checkOutput("bp accept cycle", cyc - t0, 32'd994);
      e.data = words[3]; e.par = ^words[3];
      exp_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      waitDrain(5000);
      checkOutput("bp frame_done count", fd_cyc.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < fd_cyc.size()) checkOutput("bp frame_done cycle", fd_cyc[i] - t0, 993 + 992 * i);
         else checkOutput("bp frame_done missing", 32'd0, 32'd1);
      end

      // Abort: reset in the middle of data bit 10 (bit 10 of the word is 0).
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 28'hFFFFBFF;
      checkOutput("abort in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (369) @(negedge clk);
      checkOutput("abort busy before", {31'd0, busy}, 32'd1);
      checkOutput("abort line before", {31'd0, serial_out}, 32'd0);
      mon_on = 1'b0;
      exp_q.delete();
      fd_before = fd_count;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort line after", {31'd0, serial_out}, 32'd1);
      checkOutput("abort busy after", {31'd0, busy}, 32'd0);
      checkOutput("abort in_ready after", {31'd0, in_ready}, 32'd0);
      errs = 0;
      for (int k = 0; k < 700; k++) begin
         @(negedge clk);
         if (busy !== 1'b0 || serial_out !== 1'b1) errs++;
      end
      checkOutput("abort quiet line", errs, 32'd0);
      checkOutput("abort no frame_done", fd_count - fd_before, 32'd0);
      mon_on = 1'b1;
      applyStimulus(28'h0C0FFEE, ^28'h0C0FFEE);
      waitDrain(1200);
      checkOutput("abort clean frame_done", fd_count - fd_before, 32'd1);

      // No parity, CLK_DIV=4: stop directly follows bit 27.
      @(negedge clk);
      valid_b = 1'b1;
      data_b  = 28'hA5A5A5A;
      checkOutput("nopar in_ready", {31'd0, ready_b}, 32'd1);
      errs = 0; fd_seen = 0;
      for (int k = 1; k <= 125; k++) begin
         @(negedge clk);
         if (k == 1) valid_b = 1'b0;
         if (serial_b !== expLevel(k, 28'hA5A5A5A, 1'b0, 4, 0)) errs++;
         if (busy_b !== (k >= 2 && k <= 121)) errs++;
         if (done_b !== (k == 121)) errs++;
         if (done_b === 1'b1) fd_seen++;
      end
      checkOutput("nopar waveform errs", errs, 32'd0);
      checkOutput("nopar frame_done count", fd_seen, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
